// File: rtl/mode_select_pkg.sv
// -----------------------------------------------------------------------------
// mode_select_pkg
// Shared constants and helpers for the mode_select_mux slice.
//   DEFAULT_WIDTH / DEFAULT_CHANNELS / DEFAULT_DEBOUNCE_CYCLES : parameter defaults
//   sel_width(channels)  : bits needed for a channel index (at least 1)
//   cnt_width(cycles)    : bits needed for a debounce counter reaching 'cycles'
//   step_e               : selection step decided in a given cycle
// -----------------------------------------------------------------------------
package mode_select_pkg;

    localparam int DEFAULT_WIDTH           = 10;
    localparam int DEFAULT_CHANNELS        = 4;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_NEXT = 2'd1,
        STEP_PREV = 2'd2
    } step_e;

    function automatic int sel_width(input int channels);
        return (channels <= 2) ? 1 : $clog2(channels);
    endfunction

    function automatic int cnt_width(input int cycles);
        return (cycles <= 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/mode_select_mux_if.sv
// -----------------------------------------------------------------------------
// mode_select_mux_if
// Bundles the button, data and selection signals of mode_select_mux.
// There is no valid/ready handshake on this bus: buttons are raw levels,
// DATA_IN is sampled every cycle, and SEL_CHANGED is a one-cycle strobe that
// coincides with the first cycle SEL shows its new value.
//   master : drives BTN_NEXT, BTN_PREV, DATA_IN; observes F, SEL, SEL_CHANGED
//   slave  : the mux itself (inverse directions)
// -----------------------------------------------------------------------------
interface mode_select_mux_if #(
    parameter int WIDTH    = mode_select_pkg::DEFAULT_WIDTH,
    parameter int CHANNELS = mode_select_pkg::DEFAULT_CHANNELS
);
    localparam int SEL_W = mode_select_pkg::sel_width(CHANNELS);

    logic                      BTN_NEXT;
    logic                      BTN_PREV;
    logic [CHANNELS*WIDTH-1:0] DATA_IN;
    logic [WIDTH-1:0]          F;
    logic [SEL_W-1:0]          SEL;
    logic                      SEL_CHANGED;

    modport master (
        output BTN_NEXT,
        output BTN_PREV,
        output DATA_IN,
        input  F,
        input  SEL,
        input  SEL_CHANGED
    );

    modport slave (
        input  BTN_NEXT,
        input  BTN_PREV,
        input  DATA_IN,
        output F,
        output SEL,
        output SEL_CHANGED
    );

endinterface

// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
// Two-flop synchroniser, optional debouncer, and registered press strobe for
// one raw push-button.
// Configuration macro: MODE_SELECT_DEBOUNCE_EN
//   defined   : accepted level flips only after DEBOUNCE_CYCLES consecutive
//               synchronised samples that differ from it
//   undefined : accepted level is the synchroniser output directly
// Ports:
//   clk      in  : clock
//   rst_n    in  : synchronous active-low reset
//   btn_raw  in  : asynchronous button, high = pressed
//   press    out : one-cycle pulse on each 0->1 change of the accepted level
// -----------------------------------------------------------------------------
module button_debounce
    import mode_select_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic level_prev_q, level_prev_d;
    logic press_q, press_d;
    logic level_w;

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
    end

`ifdef MODE_SELECT_DEBOUNCE_EN
    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    // Count value seen on the sample just before the one that completes the
    // stable run; that sample flips the level and clears the counter.
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        acc_d = acc_q;
        cnt_d = '0;
        if (sync2_q != acc_q) begin
            if (cnt_q == CNT_LAST) begin
                acc_d = ~acc_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign level_w = acc_q;
`else
    localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
    assign level_w = sync2_q;
`endif

    // The strobe is registered so the downstream selector sees a clean,
    // glitch-free single-cycle pulse; releases (1->0) are ignored.
    always_comb begin
        level_prev_d = level_w;
        press_d      = level_w & ~level_prev_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_prev_q <= 1'b0;
            press_q      <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            level_prev_q <= level_prev_d;
            press_q      <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/mode_select_mux.sv
// -----------------------------------------------------------------------------
// mode_select_mux
// Channel selector stepped by NEXT/PREV push-buttons, with a registered
// output of the selected channel.
// Configuration macro: MODE_SELECT_DEBOUNCE_EN (enables the button debouncers;
// when undefined DEBOUNCE_CYCLES is ignored).
// Ports:
//   CLK          in  : clock, all state on rising edge
//   RESET_N      in  : synchronous active-low reset
//   bus.BTN_NEXT in  : raw button, advances SEL (wraps CHANNELS-1 -> 0)
//   bus.BTN_PREV in  : raw button, retreats SEL (wraps 0 -> CHANNELS-1)
//   bus.DATA_IN  in  : packed channels, channel i at [i*WIDTH +: WIDTH]
//   bus.F        out : DATA_IN channel SEL, registered one cycle
//   bus.SEL      out : current channel index, always < CHANNELS
//   bus.SEL_CHANGED out : pulse in the first cycle SEL shows a new value
// -----------------------------------------------------------------------------
module mode_select_mux
    import mode_select_pkg::*;
#(
    parameter int WIDTH           = DEFAULT_WIDTH,
    parameter int CHANNELS        = DEFAULT_CHANNELS,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic               CLK,
    input  logic               RESET_N,
    mode_select_mux_if.slave   bus
);

    localparam int SEL_W = sel_width(CHANNELS);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(CHANNELS - 1);

    logic             next_ev;
    logic             prev_ev;
    step_e            step;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [WIDTH-1:0] f_q, f_d;
    logic             chg_q, chg_d;

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_next (
        .clk     (CLK),
        .rst_n   (RESET_N),
        .btn_raw (bus.BTN_NEXT),
        .press   (next_ev)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_prev (
        .clk     (CLK),
        .rst_n   (RESET_N),
        .btn_raw (bus.BTN_PREV),
        .press   (prev_ev)
    );

    // Simultaneous NEXT and PREV presses cancel each other.
    always_comb begin
        step = STEP_NONE;
        if (next_ev && !prev_ev) begin
            step = STEP_NEXT;
        end else if (prev_ev && !next_ev) begin
            step = STEP_PREV;
        end
    end

    // Explicit wrap compares keep SEL inside 0..CHANNELS-1 even when
    // CHANNELS is not a power of two.
    always_comb begin
        sel_d = sel_q;
        case (step)
            STEP_NEXT: sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
            STEP_PREV: sel_d = (sel_q == '0) ? SEL_LAST : sel_q - 1'b1;
            default:   sel_d = sel_q;
        endcase
        chg_d = (step != STEP_NONE);
    end

    // Output mux uses the currently registered SEL, giving F one cycle of
    // latency behind both SEL and DATA_IN.
    always_comb begin
        f_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sel_q == SEL_W'(i)) begin
                f_d = bus.DATA_IN[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            sel_q <= '0;
            f_q   <= '0;
            chg_q <= 1'b0;
        end else begin
            sel_q <= sel_d;
            f_q   <= f_d;
            chg_q <= chg_d;
        end
    end

    assign bus.SEL         = sel_q;
    assign bus.F           = f_q;
    assign bus.SEL_CHANGED = chg_q;

endmodule

// File: doc/mode_select_mux.md
MODE_SELECT_MUX -- requirements
Module: mode_select_mux

Interface
REQ-001 Parameter WIDTH, default 10: bit width of each data channel and of F.
REQ-002 Parameter CHANNELS, default 4: number of selectable input channels, legal range 2..16.
REQ-003 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable samples required to accept a button level, minimum 1.
REQ-004 Port CLK  input  1: single clock; all state updates on its rising edge.
REQ-005 Port RESET_N  input  1: reset, synchronous, active-low.
REQ-006 Port BTN_NEXT  input  1: raw asynchronous push-button, high = pressed; advances selection.
REQ-007 Port BTN_PREV  input  1: raw asynchronous push-button, high = pressed; retreats selection.
REQ-008 Port DATA_IN  input  CHANNELS*WIDTH: packed channels, channel i at bits [i*WIDTH +: WIDTH].
REQ-009 Port F  output  WIDTH: registered copy of the selected channel.
REQ-010 Port SEL  output  clog2(CHANNELS): current channel index.
REQ-011 Port SEL_CHANGED  output  1: one-cycle pulse when SEL takes a new value.

Function
REQ-012 Each button SHALL pass through a 2-flop synchroniser before any other logic.
REQ-013 Each synchronised button SHALL feed a debouncer holding an accepted level and a counter; a sample differing from the accepted level increments the counter, a sample equal to it clears the counter.
REQ-014 When the counter reaches DEBOUNCE_CYCLES, the accepted level SHALL flip and the counter SHALL clear in the same cycle.
REQ-015 A press event SHALL be a 0->1 transition of the accepted level, one cycle wide; releases generate no event.
REQ-016 On a NEXT-only event SHALL set SEL = SEL+1, wrapping CHANNELS-1 -> 0.
REQ-017 On a PREV-only event SHALL set SEL = SEL-1, wrapping 0 -> CHANNELS-1.
REQ-018 NEXT and PREV events in the same cycle SHALL cancel: SEL unchanged, SEL_CHANGED low.
REQ-019 SEL SHALL never hold a value >= CHANNELS, including non-power-of-two CHANNELS.
REQ-020 SEL_CHANGED SHALL be high in exactly the cycle in which SEL first shows its new value.
REQ-021 F SHALL equal DATA_IN channel SEL as sampled one cycle earlier (one-cycle registered latency, also tracking DATA_IN changes with SEL constant).
REQ-022 Latency: raw press first sampled at edge k -> SEL updated at edge k+3+DEBOUNCE_CYCLES -> F updated at edge k+4+DEBOUNCE_CYCLES, assuming no bounce.
REQ-023 A held button SHALL produce exactly one event regardless of hold duration.

Reset
REQ-024 With RESET_N low at a CLK edge: SEL=0, F=0, SEL_CHANGED=0, synchronisers=0, accepted levels=0, counters=0.
REQ-025 Reset asserted mid-debounce SHALL discard the partial count; no event is produced from pre-reset samples.
REQ-026 A button held through reset release SHALL produce one event after normal debounce latency measured from the first post-reset edge.

Configuration
REQ-027 Macro MODE_SELECT_DEBOUNCE_EN defined: debouncers per REQ-013/014 are present.
REQ-028 Macro undefined: debouncers omitted; accepted level = synchroniser output; latency per REQ-022 with DEBOUNCE_CYCLES=0; DEBOUNCE_CYCLES ignored.

Structure
REQ-029 Package mode_select_pkg SHALL hold default constants (WIDTH, CHANNELS, DEBOUNCE_CYCLES) and a function returning SEL width for a given CHANNELS (minimum 1).
REQ-030 Sub-module button_debounce (synchroniser + debouncer + press-edge output) SHALL be instantiated once per button.

Verification (WIDTH=10, CHANNELS=4, DEBOUNCE_CYCLES=4, macro defined unless stated)
REQ-031 Reset, DATA_IN={10'h3FF,10'h0AA,10'h155,10'h001} (ch3..ch0) -> SEL=0, F=10'h001 one cycle after reset release.
REQ-032 Clean BTN_NEXT press held 20 cycles, four times -> SEL 1,2,3,0, one SEL_CHANGED pulse each, F follows with one-cycle lag; F=10'h001 after wrap.
REQ-033 BTN_PREV press from SEL=0 -> SEL=3, F=10'h3FF.
REQ-034 BTN_NEXT toggling every 2 cycles for 30 cycles, then high -> exactly one event, only after 4 stable synchronised samples.
REQ-035 Both buttons pressed on the same cycle -> SEL unchanged, SEL_CHANGED never asserts; CHANNELS=3 NEXT from SEL=2 -> SEL=0.
REQ-036 Macro undefined, single-cycle-aligned press -> SEL updates at edge k+3; reset asserted 2 cycles into debounce (macro defined) -> no event.
